// File: rtl/cntr_bank_arb.sv
// Round-robin drain arbiter for the bank schedulers, with a READ/WRITE bus-mode FSM
// that inserts turnaround gaps and a single registered output stage.
module cntr_bank_arb #(
    parameter int   BANKS   = 4,
    parameter int   DQ      = 16,
    parameter int   IDX     = 7,
    parameter int   RA      = 16,
    parameter int   CA      = 10,
    parameter int   WR_BITS = 3,
    parameter int   WR_HI   = 4,
    parameter int   WR_LO   = 0,
    parameter int   TURN    = 4,
    parameter logic READ    = 1'b1,
    parameter logic WRITE   = 1'b0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [BANKS-1:0]           valid_i,
    input  logic [BANKS*DQ-1:0]        dq_i,
    input  logic [BANKS*IDX-1:0]       idx_i,
    input  logic [BANKS*RA-1:0]        ra_i,
    input  logic [BANKS*CA-1:0]        ca_i,
    input  logic [BANKS-1:0]           t_i,
    input  logic [BANKS*WR_BITS-1:0]   num_i,
    output logic [BANKS-1:0]           ready_o,
    output logic                       mode_o,
    output logic                       valid_o,
    input  logic                       ready_i,
    output logic [DQ-1:0]              dq_o,
    output logic [IDX-1:0]             idx_o,
    output logic [RA-1:0]              ra_o,
    output logic [CA-1:0]              ca_o,
    output logic                       t_o,
    output logic [$clog2(BANKS)-1:0]   ba_o
);

    localparam int BW = $clog2(BANKS);
    localparam int WT = WR_BITS + $clog2(BANKS);
    localparam int CW = $clog2(TURN + 1);

    localparam logic [WT-1:0] WR_HI_W   = WT'(WR_HI);
    localparam logic [WT-1:0] WR_LO_W   = WT'(WR_LO);
    localparam logic [CW-1:0] TURN_LAST = CW'(TURN - 1);
    localparam logic [BW-1:0] LAST_BANK = BW'(BANKS - 1);

    typedef enum logic [1:0] {
        S_RD    = 2'd0,
        S_RD2WR = 2'd1,
        S_WR    = 2'd2,
        S_WR2RD = 2'd3
    } state_t;

    state_t          state, state_nx;
    logic [CW-1:0]   cnt, cnt_nx;
    logic [BW-1:0]   rr, sel;
    logic [WT-1:0]   wr_total;
    logic [BANKS-1:0] elig;
    logic            rd_avail, wr_avail, any_elig, out_free, fire;

    always_comb begin
        wr_total = '0;
        rd_avail = 1'b0;
        wr_avail = 1'b0;
        elig     = '0;
        for (int b = 0; b < BANKS; b++) begin
            wr_total = wr_total + WT'(num_i[b*WR_BITS +: WR_BITS]);
            rd_avail = rd_avail | (valid_i[b] & (t_i[b] == READ));
            wr_avail = wr_avail | (valid_i[b] & (t_i[b] == WRITE));
            elig[b]  = valid_i[b] & (((state == S_RD) & (t_i[b] == READ)) |
                                     ((state == S_WR) & (t_i[b] == WRITE)));
        end
    end

    // First eligible bank at or above the rr pointer, wrapping past the top bank.
    always_comb begin
        sel      = rr;
        any_elig = 1'b0;
        for (int k = 0; k < BANKS; k++) begin
            int c;
            c = (int'(rr) + k) % BANKS;
            if (!any_elig && elig[c]) begin
                sel      = BW'(c);
                any_elig = 1'b1;
            end
        end
    end

    assign out_free = !valid_o | ready_i;
    assign fire     = out_free & any_elig;

    always_comb begin
        ready_o = '0;
        if (fire) ready_o[sel] = 1'b1;
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        unique case (state)
            S_RD: begin
                if (wr_total >= WR_HI_W || (wr_total != '0 && !rd_avail)) begin
                    state_nx = S_RD2WR;
                    cnt_nx   = '0;
                end
            end
            S_RD2WR: begin
                if (cnt == TURN_LAST) begin
                    state_nx = S_WR;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            S_WR: begin
                if (wr_total <= WR_LO_W || !wr_avail) begin
                    state_nx = S_WR2RD;
                    cnt_nx   = '0;
                end
            end
            S_WR2RD: begin
                if (cnt == TURN_LAST) begin
                    state_nx = S_RD;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            default: begin
                state_nx = S_RD;
                cnt_nx   = '0;
            end
        endcase
    end

    // mode_o is registered from the next state so it always matches the current state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_RD;
            cnt    <= '0;
            mode_o <= 1'b0;
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            mode_o <= (state_nx == S_RD2WR) || (state_nx == S_WR);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr      <= '0;
            valid_o <= 1'b0;
            dq_o    <= '0;
            idx_o   <= '0;
            ra_o    <= '0;
            ca_o    <= '0;
            t_o     <= 1'b0;
            ba_o    <= '0;
        end else if (fire) begin
            rr      <= (sel == LAST_BANK) ? '0 : sel + BW'(1);
            valid_o <= 1'b1;
            dq_o    <= dq_i[sel*DQ +: DQ];
            idx_o   <= idx_i[sel*IDX +: IDX];
            ra_o    <= ra_i[sel*RA +: RA];
            ca_o    <= ca_i[sel*CA +: CA];
            t_o     <= t_i[sel];
            ba_o    <= sel;
        end else if (ready_i) begin
            valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cntr_bank_arb.sv
// Directed self-checking bench for cntr_bank_arb: round-robin, mode switching,
// backpressure, wrap-around and asynchronous reset.
module tb_cntr_bank_arb;

    localparam int BANKS   = 4;
    localparam int DQ      = 16;
    localparam int IDX     = 7;
    localparam int RA      = 16;
    localparam int CA      = 10;
    localparam int WR_BITS = 3;

    logic                       clk;
    logic                       rst;
    logic [BANKS-1:0]           valid_i;
    logic [BANKS*DQ-1:0]        dq_i;
    logic [BANKS*IDX-1:0]       idx_i;
    logic [BANKS*RA-1:0]        ra_i;
    logic [BANKS*CA-1:0]        ca_i;
    logic [BANKS-1:0]           t_i;
    logic [BANKS*WR_BITS-1:0]   num_i;
    logic [BANKS-1:0]           ready_o;
    logic                       mode_o;
    logic                       valid_o;
    logic                       ready_i;
    logic [DQ-1:0]              dq_o;
    logic [IDX-1:0]             idx_o;
    logic [RA-1:0]              ra_o;
    logic [CA-1:0]              ca_o;
    logic                       t_o;
    logic [1:0]                 ba_o;

    logic                bank_v   [BANKS];
    logic                bank_t   [BANKS];
    logic [DQ-1:0]       bank_dq  [BANKS];
    logic [WR_BITS-1:0]  bank_num [BANKS];

    int tests_run;
    int tests_failed;

    cntr_bank_arb dut (
        .clk     (clk),
        .rst     (rst),
        .valid_i (valid_i),
        .dq_i    (dq_i),
        .idx_i   (idx_i),
        .ra_i    (ra_i),
        .ca_i    (ca_i),
        .t_i     (t_i),
        .num_i   (num_i),
        .ready_o (ready_o),
        .mode_o  (mode_o),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .dq_o    (dq_o),
        .idx_o   (idx_o),
        .ra_o    (ra_o),
        .ca_o    (ca_o),
        .t_o     (t_o),
        .ba_o    (ba_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Row address is the data XOR 16'h5A5A so payload routing of ra is visible too.
    always_comb begin
        valid_i = '0;
        dq_i    = '0;
        idx_i   = '0;
        ra_i    = '0;
        ca_i    = '0;
        t_i     = '0;
        num_i   = '0;
        for (int b = 0; b < BANKS; b++) begin
            valid_i[b]                  = bank_v[b];
            t_i[b]                      = bank_t[b];
            dq_i[b*DQ +: DQ]            = bank_dq[b];
            ra_i[b*RA +: RA]            = bank_dq[b] ^ 16'h5A5A;
            idx_i[b*IDX +: IDX]         = IDX'(b + 5);
            ca_i[b*CA +: CA]            = CA'(b * 3);
            num_i[b*WR_BITS +: WR_BITS] = bank_num[b];
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int b, input logic v, input logic t,
                                 input logic [DQ-1:0] dq, input logic [WR_BITS-1:0] num);
        bank_v[b]   = v;
        bank_t[b]   = t;
        bank_dq[b]  = dq;
        bank_num[b] = num;
    endtask

    task automatic clearBanks();
        for (int b = 0; b < BANKS; b++) applyStimulus(b, 1'b0, 1'b1, '0, '0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b1;
        ready_i      = 1'b1;
        clearBanks();
        #1;
        checkOutput("reset_valid", 32'(valid_o), 32'h0);
        checkOutput("reset_mode", 32'(mode_o), 32'h0);
        checkOutput("reset_ready", 32'(ready_o), 32'h0);
        checkOutput("reset_dq", 32'(dq_o), 32'h0);
        checkOutput("reset_ba", 32'(ba_o), 32'h0);
        tick();
        tick();
        rst = 1'b0;

        // Read round-robin over banks 0, 1, 3
        applyStimulus(0, 1'b1, 1'b1, 16'h1000, 3'd0);
        applyStimulus(1, 1'b1, 1'b1, 16'h1001, 3'd0);
        applyStimulus(3, 1'b1, 1'b1, 16'h1003, 3'd0);
        #1;
        checkOutput("rr_ready0", 32'(ready_o), 32'h1);
        tick();
        checkOutput("rr_valid0", 32'(valid_o), 32'h1);
        checkOutput("rr_ba0", 32'(ba_o), 32'h0);
        checkOutput("rr_dq0", 32'(dq_o), 32'h1000);
        checkOutput("rr_idx0", 32'(idx_o), 32'h5);
        checkOutput("rr_t0", 32'(t_o), 32'h1);
        checkOutput("rr_ready1", 32'(ready_o), 32'h2);
        tick();
        checkOutput("rr_ba1", 32'(ba_o), 32'h1);
        checkOutput("rr_ca1", 32'(ca_o), 32'h3);
        checkOutput("rr_ready3", 32'(ready_o), 32'h8);
        tick();
        checkOutput("rr_ba3", 32'(ba_o), 32'h3);
        checkOutput("rr_ra3", 32'(ra_o), 32'h4A59);
        checkOutput("rr_ready_wrap", 32'(ready_o), 32'h1);
        tick();
        checkOutput("rr_ba0_again", 32'(ba_o), 32'h0);
        checkOutput("rr_mode", 32'(mode_o), 32'h0);

        // Write threshold: wr_total = 4 while reads are pending
        applyStimulus(0, 1'b1, 1'b1, 16'h2000, 3'd2);
        applyStimulus(1, 1'b1, 1'b1, 16'h2001, 3'd1);
        applyStimulus(2, 1'b1, 1'b0, 16'h2002, 3'd1);
        applyStimulus(3, 1'b1, 1'b0, 16'h2003, 3'd0);
        #1;
        checkOutput("wt_last_read_grant", 32'(ready_o), 32'h2);
        tick();
        checkOutput("wt_ba_last_read", 32'(ba_o), 32'h1);
        for (int i = 0; i < 4; i++) begin
            checkOutput("wt_turn_mode", 32'(mode_o), 32'h1);
            checkOutput("wt_turn_ready", 32'(ready_o), 32'h0);
            tick();
        end
        checkOutput("wt_wr_ready2", 32'(ready_o), 32'h4);
        tick();
        checkOutput("wt_ba2", 32'(ba_o), 32'h2);
        checkOutput("wt_t2", 32'(t_o), 32'h0);
        for (int b = 0; b < BANKS; b++) bank_num[b] = '0;
        #1;
        checkOutput("wt_wr_ready3", 32'(ready_o), 32'h8);
        tick();
        checkOutput("wt_ba3", 32'(ba_o), 32'h3);
        for (int i = 0; i < 4; i++) begin
            checkOutput("wt_back_mode", 32'(mode_o), 32'h0);
            checkOutput("wt_back_ready", 32'(ready_o), 32'h0);
            tick();
        end
        checkOutput("wt_read_resume", 32'(ready_o), 32'h1);

        // Read starvation: only a single write head
        clearBanks();
        applyStimulus(2, 1'b1, 1'b0, 16'h3002, 3'd1);
        #1;
        checkOutput("st_no_grant", 32'(ready_o), 32'h0);
        tick();
        checkOutput("st_mode", 32'(mode_o), 32'h1);
        checkOutput("st_turn_ready", 32'(ready_o), 32'h0);
        repeat (4) tick();
        checkOutput("st_wr_ready", 32'(ready_o), 32'h4);
        tick();
        checkOutput("st_valid", 32'(valid_o), 32'h1);
        checkOutput("st_ba", 32'(ba_o), 32'h2);
        checkOutput("st_dq", 32'(dq_o), 32'h3002);

        // Backpressure: output held for 5 cycles, then a new pop lands
        clearBanks();
        repeat (5) tick();
        checkOutput("bp_mode_read", 32'(mode_o), 32'h0);
        checkOutput("bp_drained", 32'(valid_o), 32'h0);
        ready_i = 1'b0;
        applyStimulus(0, 1'b1, 1'b1, 16'hA0A0, 3'd0);
        applyStimulus(1, 1'b1, 1'b1, 16'hA1A1, 3'd0);
        #1;
        checkOutput("bp_first_grant", 32'(ready_o), 32'h1);
        tick();
        for (int i = 0; i < 5; i++) begin
            checkOutput("bp_stall_ready", 32'(ready_o), 32'h0);
            checkOutput("bp_stall_valid", 32'(valid_o), 32'h1);
            checkOutput("bp_stall_dq", 32'(dq_o), 32'hA0A0);
            checkOutput("bp_stall_ra", 32'(ra_o), 32'hFAFA);
            tick();
        end
        ready_i = 1'b1;
        #1;
        checkOutput("bp_release_ready", 32'(ready_o), 32'h2);
        tick();
        checkOutput("bp_new_dq", 32'(dq_o), 32'hA1A1);
        checkOutput("bp_new_ba", 32'(ba_o), 32'h1);

        // Wrap-around between banks 3 and 0
        applyStimulus(1, 1'b0, 1'b1, 16'h0000, 3'd0);
        applyStimulus(3, 1'b1, 1'b1, 16'h3333, 3'd0);
        #1;
        checkOutput("wr_ready3", 32'(ready_o), 32'h8);
        tick();
        checkOutput("wr_ba3", 32'(ba_o), 32'h3);
        checkOutput("wr_ready0", 32'(ready_o), 32'h1);
        tick();
        checkOutput("wr_ba0", 32'(ba_o), 32'h0);
        checkOutput("wr_ready3b", 32'(ready_o), 32'h8);
        tick();
        checkOutput("wr_ba3b", 32'(ba_o), 32'h3);

        // Asynchronous reset while in write mode
        clearBanks();
        applyStimulus(1, 1'b1, 1'b0, 16'h5151, 3'd4);
        #1;
        checkOutput("ar_no_grant", 32'(ready_o), 32'h0);
        repeat (5) tick();
        checkOutput("ar_mode_wr", 32'(mode_o), 32'h1);
        checkOutput("ar_ready1", 32'(ready_o), 32'h2);
        tick();
        checkOutput("ar_valid_before", 32'(valid_o), 32'h1);
        checkOutput("ar_ba1", 32'(ba_o), 32'h1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("ar_valid", 32'(valid_o), 32'h0);
        checkOutput("ar_mode", 32'(mode_o), 32'h0);
        checkOutput("ar_ready", 32'(ready_o), 32'h0);
        checkOutput("ar_dq", 32'(dq_o), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/cntr_bank_arb.md
Name: cntr_bank_arb

Overview:
- Consumer end of the bank-scheduler valid/ready drain interface.
- Collects bursts from BANKS bank schedulers and selects one request per cycle by round-robin. Only requests whose type matches the current bus mode are eligible.
- Registers the selected request toward the command/timing stage.
- Owns the READ/WRITE bus-mode state machine that drives every bank scheduler's mode input. Mode decisions use the per-bank write counts plus turnaround gaps.

Parameters:
- BANKS, 4, number of bank schedulers served
- DQ, 16, data width
- IDX, 7, request index width
- RA, 16, row address width
- CA, 10, column address width
- WR_BITS, 3, width of each bank's write-count input
- WR_HI, 4, total pending writes that force entry into write mode
- WR_LO, 0, total pending writes at or below which write mode exits
- TURN, 4, bus turnaround gap in cycles (TURN >= 1)
- READ, 1'b1, type encoding for read
- WRITE, 1'b0, type encoding for write

Ports:
- clk  in  1  clock
- rst  in  1  reset
- valid_i  in  BANKS  per-bank head-request valid
- dq_i  in  BANKS*DQ  per-bank data, bank b at [b*DQ +: DQ]
- idx_i  in  BANKS*IDX  per-bank index
- ra_i  in  BANKS*RA  per-bank row address
- ca_i  in  BANKS*CA  per-bank column address
- t_i  in  BANKS  per-bank request type
- num_i  in  BANKS*WR_BITS  per-bank pending write count
- ready_o  out  BANKS  one-hot grant/pop to bank schedulers
- mode_o  out  1  bus mode to schedulers: 1 = write, 0 = read
- valid_o  out  1  registered request valid toward command stage
- ready_i  in  1  command stage accepts
- dq_o  out  DQ  registered data
- idx_o  out  IDX  registered index
- ra_o  out  RA  registered row address
- ca_o  out  CA  registered column address
- t_o  out  1  registered type
- ba_o  out  $clog2(BANKS)  registered source bank

Behaviour:
- Clocking and reset: one clock, clk. rst is asynchronous, active-high.
- Reset values: state = S_RD, rr pointer = 0, turnaround counter = 0, mode_o = 0, valid_o = 0, all payload outputs = 0, ready_o = 0.
- wr_total: sum of all num_i fields, computed combinationally at width WR_BITS + $clog2(BANKS) with no overflow.
- rd_avail: some bank has valid_i = 1 and t_i = READ.
- wr_avail: some bank has valid_i = 1 and t_i = WRITE.
- FSM states and transitions:
  - S_RD: go to S_RD2WR when wr_total >= WR_HI, or when wr_total != 0 and !rd_avail.
  - S_RD2WR: counter counts 0..TURN-1, then go to S_WR with the counter cleared.
  - S_WR: go to S_WR2RD when wr_total <= WR_LO, or when !wr_avail.
  - S_WR2RD: counts TURN cycles, then go to S_RD.
- mode_o: 1 in S_RD2WR and S_WR; 0 in S_RD and S_WR2RD. It is registered from state.
- Eligibility: bank b is eligible when valid_i[b] = 1 and t_i[b] matches the mode (READ in S_RD, WRITE in S_WR). No bank is eligible in either turnaround state.
- out_free = !valid_o | ready_i.
- Selection: the first eligible bank scanning upward from the rr pointer with wrap-around (BANKS-1 -> 0).
- ready_o[sel] = out_free and any bank eligible. All other ready_o bits are 0, and ready_o is at most one-hot.
- ready_o is combinational from valid_i, t_i, state, valid_o and ready_i. Bank schedulers must not make valid_i depend on ready_o.
- Fire: on a cycle with ready_o[sel] = 1 and valid_i[sel] = 1, the next edge loads the payload of bank sel into the output registers, sets valid_o = 1 and ba_o = sel, and sets rr pointer = (sel + 1) mod BANKS.
- Drain: when ready_i = 1 and there is no fire, the next edge clears valid_o. The payload holds its value.
- Back-to-back: fire and drain in the same cycle give back-to-back throughput of 1 request per cycle.
- Stall: with valid_o = 1 and ready_i = 0, all ready_o = 0 and the output registers hold stable.
- Latency: 1 cycle from a pop handshake to valid_o.
- Grants already registered are not cancelled by a mode transition. The transition blocks only new grants.
- The rr pointer is held while no fire occurs. A single eligible bank may fire on consecutive cycles.
- Reset asserted mid-transfer clears valid_o immediately (asynchronously) and returns the FSM to S_RD. A pending request in the output register is dropped.

Test Plan:
- Read round-robin: banks 0, 1, 3 hold READ heads, ready_i = 1, wr_total = 0 → pops 0, 1, 3, 0, … one per cycle. valid_o follows 1 cycle later with ba_o = 0, 1, 3. mode_o stays 0.
- Write threshold: num_i = {2,1,1,0}, so wr_total = 4 while reads pending → S_RD2WR; mode_o = 1; no ready_o for 4 cycles; then write heads pop. When num_i sums to 0 → S_WR2RD; mode_o = 0; 4 idle cycles; reads resume.
- Read starvation switch: no READ heads, num_i total = 1 → immediate S_RD2WR; after 4 cycles the single write pops.
- Backpressure: ready_i = 0 with valid_o = 1 for 5 cycles → ready_o = 0 and dq_o/ra_o stable for 5 cycles. On ready_i = 1 a new pop lands in the same cycle.
- Wrap: rr pointer = 3, only banks 3 and 0 eligible → order 3, 0, 3.
- Async reset: assert rst mid-stream in S_WR → valid_o = 0, mode_o = 0, ready_o = 0 before the next clk edge.
